// File: rtl/xpu_slice_pkg.sv
// xpu_slice_pkg: shared config type and window helpers for the time-slice generator
package xpu_slice_pkg;
  localparam int CNT_WIDTH_DEF = 20;
  localparam int CNT_WIDTH_MAX = 32;
  typedef logic [CNT_WIDTH_MAX-1:0] cnt_t;
  typedef struct packed {
    cnt_t total;
    cnt_t start;
    cnt_t stop;
  } slice_cfg_t;
  function automatic logic win_hit(cnt_t cnt, cnt_t start, cnt_t stop);
    return (start <= stop) ? (cnt >= start && cnt <= stop) : (cnt >= start || cnt <= stop);
  endfunction
  // Result is taken modulo 2^CNT_WIDTH by the caller, matching a CNT_WIDTH+1 bit sum truncated
  function automatic cnt_t win_remain(cnt_t cnt, cnt_t total, cnt_t stop);
    return (cnt <= stop) ? stop - cnt : total - cnt + stop + cnt_t'(1);
  endfunction
endpackage

// File: rtl/time_slice_chan.sv
// time_slice_chan: one channel's period counter, shadow/active config and registered slice outputs
module time_slice_chan import xpu_slice_pkg::*; #(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pulse_i,
  input  logic                 resync_i,
  input  logic                 wr_i,
  input  slice_cfg_t           cfg_i,
  input  logic                 en_i,
  output logic                 en_o,
  output logic                 start_o,
  output logic [CNT_WIDTH-1:0] remain_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  slice_cfg_t sh_q, sh_d, act_q, act_d;
  logic en_q, en_d, commit, live;
  // While disabled the active copy tracks the incoming shadow so enabling starts on the new config
  always_comb begin
    commit = resync_i || (pulse_i && cnt_t'(cnt_q) >= act_q.total);
    sh_d = wr_i ? cfg_i : sh_q;
    en_d = wr_i ? en_i : en_q;
    act_d = !en_q ? sh_d : commit ? sh_q : act_q;
    cnt_d = (!en_q || commit) ? '0 : pulse_i ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    live = en_q && win_hit(cnt_t'(cnt_q), act_q.start, act_q.stop);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      sh_q <= '0;
      act_q <= '0;
      en_q <= 1'b0;
      en_o <= 1'b0;
      start_o <= 1'b0;
      remain_o <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      act_q <= act_d;
      en_q <= en_d;
      en_o <= live;
      start_o <= live && !en_o;
      remain_o <= live ? CNT_WIDTH'(win_remain(cnt_t'(cnt_q), act_q.total, act_q.stop)) : '0;
    end
  end
endmodule

// File: rtl/time_slice_gen_mc.sv
// time_slice_gen_mc: multi-channel TSF time-slice generator with period-boundary config commit
module time_slice_gen_mc import xpu_slice_pkg::*; #(
  parameter int NUM_SLICE = 4,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int IDX_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           tsf_pulse_1M,
  input  logic                           tsf_resync,
  input  logic                           cfg_wr,
  input  logic [IDX_WIDTH-1:0]           cfg_idx,
  input  logic [CNT_WIDTH-1:0]           cfg_total,
  input  logic [CNT_WIDTH-1:0]           cfg_start,
  input  logic [CNT_WIDTH-1:0]           cfg_end,
  input  logic                           cfg_en,
  output logic [NUM_SLICE-1:0]           slice_en,
  output logic [NUM_SLICE-1:0]           slice_start,
  output logic [NUM_SLICE*CNT_WIDTH-1:0] slice_remain
);
  slice_cfg_t cfg;
  assign cfg = {cnt_t'(cfg_total), cnt_t'(cfg_start), cnt_t'(cfg_end)};
  // Out-of-range indices match no channel, so such writes fall away
  for (genvar i = 0; i < NUM_SLICE; i++) begin : g_ch
    time_slice_chan #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .pulse_i  (tsf_pulse_1M),
      .resync_i (tsf_resync),
      .wr_i     (cfg_wr && cfg_idx == IDX_WIDTH'(i)),
      .cfg_i    (cfg),
      .en_i     (cfg_en),
      .en_o     (slice_en[i]),
      .start_o  (slice_start[i]),
      .remain_o (slice_remain[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule

// File: tb/tb_time_slice_gen_mc.sv
// tb_time_slice_gen_mc: directed checks of windows, wrap, commit, shrink, resync, disable and reset
module tb_time_slice_gen_mc;
  localparam int NS = 4, CW = 20, IW = 4;
  logic clk = 1'b0, rstn = 1'b0, tsf_pulse_1M = 1'b0, tsf_resync = 1'b0, cfg_wr = 1'b0, cfg_en = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_total = '0, cfg_start = '0, cfg_end = '0;
  logic [NS-1:0] slice_en, slice_start;
  logic [NS*CW-1:0] slice_remain;
  int checks = 0, failures = 0, np = 0;
  bit en0_t[10] = '{0,0,1,1,1,1,0,0,0,0};
  int rm0_t[10] = '{0,0,3,2,1,0,0,0,0,0};
  bit st0_t[10] = '{0,0,1,0,0,0,0,0,0,0};
  bit en1_t[10] = '{1,1,0,0,0,0,0,0,1,1};
  int rm1_t[10] = '{1,0,0,0,0,0,0,0,3,2};
  bit st1_t[10] = '{0,0,0,0,0,0,0,0,1,0};
  bit sh_en[12] = '{0,0,0,0,1,1,1,1,1,1,1,1};
  int sh_rm[12] = '{0,0,0,0,2,1,0,2,1,0,5,4};
  always #5 clk = ~clk;
  time_slice_gen_mc #(.NUM_SLICE(NS), .CNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn), .tsf_pulse_1M(tsf_pulse_1M), .tsf_resync(tsf_resync),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_total(cfg_total), .cfg_start(cfg_start),
    .cfg_end(cfg_end), .cfg_en(cfg_en), .slice_en(slice_en), .slice_start(slice_start),
    .slice_remain(slice_remain)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [CW-1:0] rem(input int ch);
    return slice_remain[ch*CW +: CW];
  endfunction
  task automatic setcfg(input int idx, input int t, input int s, input int e, input logic en);
    cfg_idx = IW'(idx);
    cfg_total = CW'(t);
    cfg_start = CW'(s);
    cfg_end = CW'(e);
    cfg_en = en;
  endtask
  task automatic wr(input int idx, input int t, input int s, input int e, input logic en);
    setcfg(idx, t, s, e, en);
    cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
  endtask
  task automatic step();
    tsf_pulse_1M = 1'b1;
    cyc();
    tsf_pulse_1M = 1'b0;
    tsf_resync = 1'b0;
    cfg_wr = 1'b0;
    cyc();
    np++;
  endtask
  task automatic chk01(input int c);
    check($sformatf("ch0_en c=%0d", c), slice_en[0], en0_t[c]);
    check($sformatf("ch0_rem c=%0d", c), rem(0), rm0_t[c]);
    check($sformatf("ch0_start c=%0d", c), slice_start[0], st0_t[c]);
    check($sformatf("ch1_en c=%0d", c), slice_en[1], en1_t[c]);
    check($sformatf("ch1_rem c=%0d", c), rem(1), rm1_t[c]);
    check($sformatf("ch1_start c=%0d", c), slice_start[1], st1_t[c]);
  endtask
  initial begin
    cyc();
    cyc();
    check("rst_en", slice_en, 0);
    check("rst_start", slice_start, 0);
    check("rst_remain", slice_remain, 0);
    rstn = 1'b1;
    cyc();
    wr(0, 9, 2, 5, 1'b1);
    wr(1, 9, 8, 1, 1'b1);
    cyc();
    cyc();
    for (int k = 1; k <= 20; k++) begin
      step();
      chk01(np % 10);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk01(np % 10);
    end
    wr(0, 4, 0, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk01(np % 10);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("commit_en k=%0d", k), slice_en[0], k % 5 == 0);
      check($sformatf("commit_start k=%0d", k), slice_start[0], k % 5 == 0);
      check($sformatf("commit_rem k=%0d", k), rem(0), 0);
    end
    wr(0, 2, 0, 2, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k == 10) wr(2, 3, 0, 3, 1'b1);
      if (k == 7) begin
        setcfg(0, 5, 0, 5, 1'b1);
        cfg_wr = 1'b1;
      end
      step();
      check($sformatf("shrink_en k=%0d", k), slice_en[0], sh_en[k]);
      check($sformatf("shrink_rem k=%0d", k), rem(0), sh_rm[k]);
    end
    check("pre_resync_ch2_rem", rem(2), 1);
    tsf_resync = 1'b1;
    step();
    check("resync_ch0_rem", rem(0), 5);
    check("resync_ch1_en", slice_en[1], 1);
    check("resync_ch1_rem", rem(1), 1);
    check("resync_ch1_start", slice_start[1], 1);
    check("resync_ch2_rem", rem(2), 3);
    wr(2, 3, 0, 3, 1'b0);
    cyc();
    check("dis_ch2_en", slice_en[2], 0);
    check("dis_ch2_rem", rem(2), 0);
    step();
    check("dis_hold_ch2_en", slice_en[2], 0);
    check("dis_hold_ch0_rem", rem(0), 4);
    wr(2, 3, 0, 3, 1'b1);
    cyc();
    check("reen_ch2_en", slice_en[2], 1);
    check("reen_ch2_rem", rem(2), 3);
    wr(NS, 0, 0, 0, 1'b0);
    step();
    check("illegal_en", slice_en, 4'b0101);
    check("illegal_ch0_rem", rem(0), 3);
    check("illegal_ch2_rem", rem(2), 2);
    check("illegal_ch3_rem", rem(3), 0);
    rstn = 1'b0;
    cyc();
    check("midrst_en", slice_en, 0);
    check("midrst_start", slice_start, 0);
    check("midrst_remain", slice_remain, 0);
    rstn = 1'b1;
    step();
    check("postrst_en", slice_en, 0);
    check("postrst_remain", slice_remain, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
